// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: valid/ready pipeline register with 2-entry skid, stall, flush; PIPE_SKID_PERF_EN adds a backpressure counter
module pipe_skid_stage #(
  parameter int WIDTH = 32,
  parameter bit DATA_RESET = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
`ifdef PIPE_SKID_PERF_EN
  output logic [15:0]      perf_stall_cnt_o,
`endif
  output logic [1:0]       occupancy_o
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d, skid_q, skid_d;
  logic in_fire, out_fire;
  assign in_ready_o  = (state_q != TWO) & ~stall_i;
  assign out_valid_o = (state_q != EMPTY);
  assign occupancy_o = state_q;
  assign out_data_o  = main_q;
  assign in_fire     = in_valid_i & in_ready_o;
  assign out_fire    = out_valid_o & out_ready_i & ~stall_i;
  // stall needs no branch of its own: both fires are already gated by it
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_i) state_d = EMPTY;
    else begin
      case (state_q)
        EMPTY: if (in_fire) begin
          state_d = ONE;
          main_d  = in_data_i;
        end
        ONE: begin
          if (in_fire && out_fire) main_d = in_data_i;
          else if (in_fire) begin
            state_d = TWO;
            skid_d  = in_data_i;
          end else if (out_fire) state_d = EMPTY;
        end
        TWO: if (out_fire) begin
          state_d = ONE;
          main_d  = skid_q;
        end
        default: state_d = EMPTY;
      endcase
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      if (DATA_RESET) begin
        main_q <= '0;
        skid_q <= '0;
      end
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end
`ifdef PIPE_SKID_PERF_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) perf_stall_cnt_o <= '0;
    else if (out_valid_o && !out_ready_i && !stall_i && perf_stall_cnt_o != 16'hFFFF)
      perf_stall_cnt_o <= perf_stall_cnt_o + 16'd1;
  end
`endif
endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb_pipe_skid_stage: table-driven directed checks of pipe_skid_stage
module tb_pipe_skid_stage;
  logic clk = 1'b0;
  logic rst, stall, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_data, out_data;
  logic [1:0] occ;
`ifdef PIPE_SKID_PERF_EN
  logic [15:0] perf;
`endif
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_skid_stage #(.WIDTH(32), .DATA_RESET(1'b1)) dut (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
`ifdef PIPE_SKID_PERF_EN
    .perf_stall_cnt_o(perf),
`endif
    .occupancy_o(occ)
  );

  typedef struct {
    logic rst, stall, flush, iv;
    logic [31:0] din;
    logic ordy;
    logic ir, ov;
    logic [31:0] dout;
    logic [1:0] occ;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input logic r, s, f, iv, input logic [31:0] d, input logic ordy,
                     input logic ir, ov, input logic [31:0] dout, input logic [1:0] o);
    vec_t v;
    v.rst = r; v.stall = s; v.flush = f; v.iv = iv; v.din = d; v.ordy = ordy;
    v.ir = ir; v.ov = ov; v.dout = dout; v.occ = o;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act, exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h want %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, s, f, iv, input logic [31:0] d, input logic ordy);
    rst = r; stall = s; flush = f; in_valid = iv; in_data = d; out_ready = ordy;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //   rst st fl iv din    ordy | ir ov dout  occ
    add(0, 0, 0, 1, 32'h1, 1,  1, 1, 32'h1, 1);
    add(0, 0, 0, 1, 32'h2, 1,  1, 1, 32'h2, 1);
    add(0, 0, 0, 1, 32'h3, 1,  1, 1, 32'h3, 1);
    add(0, 0, 0, 0, 32'h0, 1,  1, 0, 32'h3, 0);
    add(0, 0, 0, 1, 32'hA, 0,  1, 1, 32'hA, 1);
    add(0, 0, 0, 1, 32'hB, 0,  1, 1, 32'hA, 2);
    add(0, 0, 0, 1, 32'hD, 0,  0, 1, 32'hA, 2);
    add(0, 0, 0, 0, 32'h0, 1,  0, 1, 32'hB, 1);
    add(0, 0, 0, 0, 32'h0, 1,  1, 0, 32'hB, 0);
    add(0, 0, 0, 1, 32'hA, 0,  1, 1, 32'hA, 1);
    add(0, 0, 0, 1, 32'hB, 0,  1, 1, 32'hA, 2);
    add(0, 1, 0, 0, 32'h0, 1,  0, 1, 32'hA, 2);
    add(0, 1, 0, 0, 32'h0, 1,  0, 1, 32'hA, 2);
    add(0, 1, 0, 0, 32'h0, 1,  0, 1, 32'hA, 2);
    add(0, 0, 0, 0, 32'h0, 1,  0, 1, 32'hB, 1);
    add(0, 0, 0, 0, 32'h0, 1,  1, 0, 32'hB, 0);
    add(0, 0, 0, 1, 32'hE, 0,  1, 1, 32'hE, 1);
    add(0, 1, 0, 1, 32'hF, 1,  0, 1, 32'hE, 1);
    add(0, 0, 0, 0, 32'h0, 1,  1, 0, 32'hE, 0);
    add(0, 0, 0, 1, 32'hA, 0,  1, 1, 32'hA, 1);
    add(0, 0, 0, 1, 32'hB, 0,  1, 1, 32'hA, 2);
    add(0, 1, 1, 1, 32'hC, 1,  0, 0, 32'hA, 0);
    add(0, 0, 0, 0, 32'h0, 1,  1, 0, 32'hA, 0);
    add(0, 0, 0, 1, 32'h5, 0,  1, 1, 32'h5, 1);
    add(0, 0, 1, 1, 32'h6, 1,  1, 0, 32'h5, 0);
    add(0, 0, 0, 1, 32'hA, 0,  1, 1, 32'hA, 1);
    add(0, 0, 0, 1, 32'hB, 0,  1, 1, 32'hA, 2);
    add(1, 1, 0, 1, 32'h7, 1,  0, 0, 32'h0, 0);
    add(0, 0, 0, 0, 32'h0, 0,  1, 0, 32'h0, 0);

    drive(1, 0, 0, 0, 32'h0, 0);
    tick;
    tick;
    chk("reset_valid", -1, {31'b0, out_valid}, 32'h0);
    chk("reset_occ", -1, {30'b0, occ}, 32'h0);
    chk("reset_data", -1, out_data, 32'h0);
    drive(0, 0, 0, 0, 32'h0, 0);
    #1;
    chk("reset_ready", -1, {31'b0, in_ready}, 32'h1);
    tick;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].stall, vecs[i].flush, vecs[i].iv, vecs[i].din, vecs[i].ordy);
      #1;
      chk("in_ready", i, {31'b0, in_ready}, {31'b0, vecs[i].ir});
      tick;
      chk("out_valid", i, {31'b0, out_valid}, {31'b0, vecs[i].ov});
      chk("out_data", i, out_data, vecs[i].dout);
      chk("occupancy", i, {30'b0, occ}, {30'b0, vecs[i].occ});
    end

`ifdef PIPE_SKID_PERF_EN
    drive(1, 0, 0, 0, 32'h0, 0);
    tick;
    chk("perf_reset", 100, {16'b0, perf}, 32'd0);
    drive(0, 0, 0, 1, 32'h9, 0);
    tick;
    drive(0, 0, 0, 0, 32'h0, 0);
    for (int i = 0; i < 5; i++) tick;
    chk("perf_backpressure", 101, {16'b0, perf}, 32'd5);
    drive(0, 1, 0, 0, 32'h0, 0);
    tick;
    tick;
    chk("perf_stall_hold", 102, {16'b0, perf}, 32'd5);
    drive(0, 0, 1, 0, 32'h0, 1);
    tick;
    chk("perf_flush_keep", 103, {16'b0, perf}, 32'd5);
    drive(1, 0, 0, 0, 32'h0, 0);
    tick;
    chk("perf_clear", 104, {16'b0, perf}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
